// File: rtl/eth_rx_frame_check_if.sv
// PHY receive bus, forwarded-byte stream and per-frame status of the Ethernet RX frame checker.
// The master drives the PHY side; the slave (the checker) drives everything else.
interface eth_rx_frame_check_if;
    logic        rx_dv;
    logic        rx_er;
    logic [7:0]  rx_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        stat_valid;
    logic        stat_good;
    logic        stat_crc_err;
    logic        stat_len_err;
    logic        stat_phy_err;
    logic [10:0] stat_len;
    logic [1:0]  stat_dst_port;
    logic [1:0]  stat_src_port;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    modport master (
        output rx_dv, rx_er, rx_data,
        input  out_data, out_valid, out_sof, stat_valid, stat_good, stat_crc_err,
               stat_len_err, stat_phy_err, stat_len, stat_dst_port, stat_src_port,
               good_cnt, bad_cnt
    );

    modport slave (
        input  rx_dv, rx_er, rx_data,
        output out_data, out_valid, out_sof, stat_valid, stat_good, stat_crc_err,
               stat_len_err, stat_phy_err, stat_len, stat_dst_port, stat_src_port,
               good_cnt, bad_cnt
    );
endinterface

// File: rtl/eth_rx_frame_check.sv
// Ethernet RX frame checker: preamble/SFD detection, FCS strip and CRC check, length/PHY error status.
// Optional good/bad frame counters are built only when ETH_RX_STATS_EN is defined.
module eth_rx_frame_check #(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input logic               clk,
    input logic               rst,
    eth_rx_frame_check_if.slave bus
);
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [10:0] LEN_MAX  = 11'(MAX_LEN);
    localparam logic [10:0] LEN_MIN  = 11'(MIN_LEN);
    localparam logic [10:0] LEN_SAT  = 11'h7FF;

    typedef enum logic [1:0] {IDLE, PREAMBLE, BODY, DROP} state_t;
    state_t state_q, state_d;

    logic [31:0] crc_q, crc_d;
    logic [31:0] dl_q;
    logic [10:0] cnt_q, cnt_d;
    logic        phy_q;
    logic [1:0]  dst_q, src_q;
    logic        start_body, end_frame, body_beat;
    logic        crc_err_d, len_err_d, good_d;

    logic [7:0]  out_data_q;
    logic        out_valid_q, out_sof_q;
    logic        stat_valid_q, stat_good_q, stat_crc_q, stat_len_err_q, stat_phy_q;
    logic [10:0] stat_len_q;
    logic [1:0]  stat_dst_q, stat_src_q;

    // Input byte enters LSB first into an MSB-first shift register.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[31] ^ b[k];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ CRC_POLY;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start_body = 1'b0;
        end_frame  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_dv) state_d = (bus.rx_data == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!bus.rx_dv) begin
                    state_d = IDLE;
                end else if (bus.rx_data == 8'hD5) begin
                    state_d    = BODY;
                    start_body = 1'b1;
                end else if (bus.rx_data != 8'h55) begin
                    state_d = DROP;
                end
            end
            BODY: begin
                if (!bus.rx_dv) begin
                    state_d   = IDLE;
                    end_frame = 1'b1;
                end
            end
            DROP: begin
                if (!bus.rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The byte leaving the 4-byte delay line is known not to be FCS: it feeds the CRC and the output.
    always_comb begin
        body_beat = (state_q == BODY) && bus.rx_dv;
        cnt_d     = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 11'd1;
        crc_d     = crc_byte(crc_q, dl_q[31:24]);
        crc_err_d = (cnt_q < 11'd4) || (dl_q != crc_q);
        len_err_d = (cnt_q < LEN_MIN) || (cnt_q > LEN_MAX);
        good_d    = !crc_err_d && !len_err_d && !phy_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q          <= CRC_INIT;
            dl_q           <= '0;
            cnt_q          <= '0;
            phy_q          <= 1'b0;
            dst_q          <= '0;
            src_q          <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            stat_valid_q   <= 1'b0;
            stat_good_q    <= 1'b0;
            stat_crc_q     <= 1'b0;
            stat_len_err_q <= 1'b0;
            stat_phy_q     <= 1'b0;
            stat_len_q     <= '0;
            stat_dst_q     <= '0;
            stat_src_q     <= '0;
        end else begin
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            stat_valid_q <= 1'b0;
            if (start_body) begin
                crc_q <= CRC_INIT;
                dl_q  <= '0;
                cnt_q <= '0;
                phy_q <= 1'b0;
                dst_q <= '0;
                src_q <= '0;
            end else if (body_beat) begin
                dl_q  <= {dl_q[23:0], bus.rx_data};
                cnt_q <= cnt_d;
                if (bus.rx_er)        phy_q <= 1'b1;
                if (cnt_q == 11'd0)   dst_q <= bus.rx_data[1:0];
                if (cnt_q == 11'd6)   src_q <= bus.rx_data[1:0];
                if (cnt_q >= 11'd4) begin
                    crc_q <= crc_d;
                    if (cnt_q < LEN_MAX) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= dl_q[31:24];
                        out_sof_q   <= (cnt_q == 11'd4);
                    end
                end
            end
            if (end_frame) begin
                stat_valid_q   <= 1'b1;
                stat_good_q    <= good_d;
                stat_crc_q     <= crc_err_d;
                stat_len_err_q <= len_err_d;
                stat_phy_q     <= phy_q;
                stat_len_q     <= cnt_q;
                stat_dst_q     <= dst_q;
                stat_src_q     <= src_q;
            end
        end
    end

`ifdef ETH_RX_STATS_EN
    logic [15:0] good_cnt_q, bad_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else if (end_frame) begin
            if (good_d) begin
                if (good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 16'd1;
            end else begin
                if (bad_cnt_q != 16'hFFFF) bad_cnt_q <= bad_cnt_q + 16'd1;
            end
        end
    end

    assign bus.good_cnt = good_cnt_q;
    assign bus.bad_cnt  = bad_cnt_q;
`else
    assign bus.good_cnt = '0;
    assign bus.bad_cnt  = '0;
`endif

    assign bus.out_data      = out_data_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_sof       = out_sof_q;
    assign bus.stat_valid    = stat_valid_q;
    assign bus.stat_good     = stat_good_q;
    assign bus.stat_crc_err  = stat_crc_q;
    assign bus.stat_len_err  = stat_len_err_q;
    assign bus.stat_phy_err  = stat_phy_q;
    assign bus.stat_len      = stat_len_q;
    assign bus.stat_dst_port = stat_dst_q;
    assign bus.stat_src_port = stat_src_q;
endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Scoreboard bench for eth_rx_frame_check: directed frames plus randomized frames against a frame-level model.
module tb_eth_rx_frame_check;
    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
    } beat_t;

    typedef struct packed {
        logic        good;
        logic        crc;
        logic        len_e;
        logic        phy;
        logic [10:0] len;
        logic [1:0]  dst;
        logic [1:0]  src;
    } stat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    eth_rx_frame_check_if bus_if();

    eth_rx_frame_check #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int good_model = 0;
    int bad_model = 0;

    beat_t exp_beats[$];
    stat_t exp_stats[$];
    logic [7:0] pre_q[$];
    logic [7:0] body_q[$];
    beat_t mon_b;
    stat_t mon_s;
    stat_t got_s;

    // CRC over the first cnt body bytes, written as whole-byte XOR of the bit-reversed byte.
    function automatic logic [31:0] ref_crc(input int cnt);
        logic [31:0] c;
        logic [7:0]  b, r;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < cnt; i++) begin
            b = body_q[i];
            for (int k = 0; k < 8; k++) r[k] = b[7-k];
            c = c ^ {r, 24'h0};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        end
        return c;
    endfunction

    task automatic make_body(input int n, input logic [7:0] da, input logic [7:0] sa);
        logic [31:0] c;
        body_q.delete();
        for (int i = 0; i < n; i++) body_q.push_back(8'($urandom_range(0, 255)));
        if (n > 0) body_q[0] = da;
        if (n > 6) body_q[6] = sa;
        if (n >= 4) begin
            c = ref_crc(n - 4);
            body_q[n-4] = c[31:24];
            body_q[n-3] = c[23:16];
            body_q[n-2] = c[15:8];
            body_q[n-1] = c[7:0];
        end
    endtask

    task automatic make_pre(input int n55);
        pre_q.delete();
        for (int i = 0; i < n55; i++) pre_q.push_back(8'h55);
        pre_q.push_back(8'hD5);
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk);
        bus_if.rx_dv   = dv;
        bus_if.rx_er   = er;
        bus_if.rx_data = d;
    endtask

    task automatic check_zero(input string name);
        logic [31:0] v;
        v = {bus_if.out_data, bus_if.out_valid, bus_if.out_sof, bus_if.stat_valid,
             bus_if.stat_good, bus_if.stat_crc_err, bus_if.stat_len_err, bus_if.stat_phy_err,
             bus_if.stat_len, bus_if.stat_dst_port, bus_if.stat_src_port};
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL %s outputs got=%08h want=00000000", name, v);
        end
    endtask

    // Expectations come from the frame as a whole: preamble shape, body length, FCS, error byte.
    task automatic send_frame(input int er_idx, input int rst_idx, input int gap);
        bit          pre_ok;
        int          n, lim, fwd;
        logic [31:0] fcs;
        stat_t       s;
        n      = body_q.size();
        pre_ok = (pre_q.size() >= 2) && (pre_q[pre_q.size()-1] == 8'hD5);
        for (int i = 0; i < pre_q.size() - 1; i++) if (pre_q[i] != 8'h55) pre_ok = 1'b0;
        if (pre_ok) begin
            lim = (rst_idx >= 0) ? rst_idx : n;
            fwd = (lim > 4) ? lim - 4 : 0;
            if (fwd > MAX_LEN - 4) fwd = MAX_LEN - 4;
            for (int i = 0; i < fwd; i++) exp_beats.push_back('{d: body_q[i], sof: (i == 0)});
            if (rst_idx < 0) begin
                fcs     = (n >= 4) ? {body_q[n-4], body_q[n-3], body_q[n-2], body_q[n-1]} : 32'h0;
                s.crc   = (n < 4) || (fcs != ref_crc(n - 4));
                s.len_e = (n < MIN_LEN) || (n > MAX_LEN);
                s.phy   = (er_idx >= 0) && (er_idx < n);
                s.good  = !s.crc && !s.len_e && !s.phy;
                s.len   = (n > 2047) ? 11'd2047 : 11'(n);
                s.dst   = (n > 0) ? body_q[0][1:0] : 2'd0;
                s.src   = (n > 6) ? body_q[6][1:0] : 2'd0;
                exp_stats.push_back(s);
                if (s.good) good_model++;
                else        bad_model++;
            end
        end
        for (int i = 0; i < pre_q.size(); i++) drive(1'b1, 1'b0, pre_q[i]);
        for (int i = 0; i < n; i++) begin
            if (i == rst_idx) begin
                @(negedge clk);
                rst = 1'b1;
                bus_if.rx_dv = 1'b0;
                bus_if.rx_er = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                good_model = 0;
                bad_model  = 0;
                check_zero("mid_frame_reset");
                break;
            end
            drive(1'b1, (i == er_idx), body_q[i]);
        end
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    always @(negedge clk) begin
        if (bus_if.out_valid === 1'b1) begin
            checks++;
            if (exp_beats.size() == 0) begin
                errors++;
                $display("FAIL out_beat unexpected data=%02h sof=%0b", bus_if.out_data, bus_if.out_sof);
            end else begin
                mon_b = exp_beats.pop_front();
                if (bus_if.out_data !== mon_b.d || bus_if.out_sof !== mon_b.sof) begin
                    errors++;
                    $display("FAIL out_beat got data=%02h sof=%0b want data=%02h sof=%0b",
                             bus_if.out_data, bus_if.out_sof, mon_b.d, mon_b.sof);
                end
            end
        end
        if (bus_if.stat_valid === 1'b1) begin
            checks++;
            got_s = '{good: bus_if.stat_good, crc: bus_if.stat_crc_err, len_e: bus_if.stat_len_err,
                      phy: bus_if.stat_phy_err, len: bus_if.stat_len,
                      dst: bus_if.stat_dst_port, src: bus_if.stat_src_port};
            if (exp_stats.size() == 0) begin
                errors++;
                $display("FAIL stat unexpected got=%05h", got_s);
            end else begin
                mon_s = exp_stats.pop_front();
                if (got_s !== mon_s) begin
                    errors++;
                    $display("FAIL stat got good=%0b crc=%0b len_err=%0b phy=%0b len=%0d dst=%0d src=%0d want good=%0b crc=%0b len_err=%0b phy=%0b len=%0d dst=%0d src=%0d",
                             got_s.good, got_s.crc, got_s.len_e, got_s.phy, got_s.len, got_s.dst, got_s.src,
                             mon_s.good, mon_s.crc, mon_s.len_e, mon_s.phy, mon_s.len, mon_s.dst, mon_s.src);
                end
            end
        end
    end

    initial begin
        int exp_good, exp_bad, n, idx, er;
        bus_if.rx_dv   = 1'b0;
        bus_if.rx_er   = 1'b0;
        bus_if.rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("reset_state");
        checks++;
        if (bus_if.good_cnt !== 16'h0 || bus_if.bad_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_counters got good=%0d bad=%0d want 0 0", bus_if.good_cnt, bus_if.bad_cnt);
        end
        drive(1'b0, 1'b0, 8'h00);

        make_pre(7); make_body(64, 8'h01, 8'h03); send_frame(-1, -1, 3);
        make_pre(7); make_body(64, 8'h01, 8'h03); body_q[30] = body_q[30] ^ 8'h01; send_frame(-1, -1, 3);
        make_pre(7); make_body(40, 8'h02, 8'h01); send_frame(-1, -1, 3);
        make_pre(7); make_body(1600, 8'h03, 8'h02); send_frame(-1, -1, 3);
        pre_q.delete();
        pre_q.push_back(8'h55); pre_q.push_back(8'h12); pre_q.push_back(8'h55); pre_q.push_back(8'hD5);
        make_body(64, 8'h01, 8'h03); send_frame(-1, -1, 2);
        make_pre(7); make_body(64, 8'h01, 8'h03); send_frame(-1, -1, 2);
        make_pre(7); make_body(64, 8'h02, 8'h02); send_frame(20, -1, 2);
        make_pre(7); make_body(150, 8'h01, 8'h01); send_frame(-1, 100, 2);
        make_pre(7); make_body(70, 8'h01, 8'h03); send_frame(-1, -1, 2);
        make_pre(3); make_body(2, 8'h01, 8'h00); send_frame(-1, -1, 2);

        for (int f = 0; f < 14; f++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(50, 130));
            make_pre(int'($urandom_range(1, 7)));
            if ($urandom_range(0, 4) == 0) pre_q[$urandom_range(0, pre_q.size() - 1)] = 8'h12;
            make_body(n, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if (n > 0 && $urandom_range(0, 2) == 0) begin
                idx = int'($urandom_range(0, n - 1));
                body_q[idx] = body_q[idx] ^ 8'(1 << $urandom_range(0, 7));
            end
            er = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            send_frame(er, -1, int'($urandom_range(1, 3)));
        end

        repeat (10) @(negedge clk);
        checks++;
        if (exp_beats.size() != 0) begin
            errors++;
            $display("FAIL beats_drained got_left=%0d want 0", exp_beats.size());
        end
        checks++;
        if (exp_stats.size() != 0) begin
            errors++;
            $display("FAIL stats_drained got_left=%0d want 0", exp_stats.size());
        end
`ifdef ETH_RX_STATS_EN
        exp_good = (good_model > 65535) ? 65535 : good_model;
        exp_bad  = (bad_model > 65535) ? 65535 : bad_model;
`else
        exp_good = 0;
        exp_bad  = 0;
`endif
        checks++;
        if (int'(bus_if.good_cnt) != exp_good) begin
            errors++;
            $display("FAIL good_cnt got=%0d want=%0d", bus_if.good_cnt, exp_good);
        end
        checks++;
        if (int'(bus_if.bad_cnt) != exp_bad) begin
            errors++;
            $display("FAIL bad_cnt got=%0d want=%0d", bus_if.bad_cnt, exp_bad);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eth_rx_frame_check.md
ETH_RX_FRAME_CHECK -- requirements
Module: eth_rx_frame_check

Interface
REQ-001 Parameter MAX_LEN, default 1518: maximum legal body length in bytes (DA through FCS).
REQ-002 Parameter MIN_LEN, default 64: minimum legal body length in bytes.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_dv  in  1  PHY receive data valid; contiguous high for one frame.
REQ-006 rx_er  in  1  PHY receive error.
REQ-007 rx_data  in  8  PHY receive byte.
REQ-008 out_data  out  8  forwarded body byte (DA through last payload byte; FCS stripped).
REQ-009 out_valid  out  1  out_data qualifier.
REQ-010 out_sof  out  1  high with the first forwarded byte of a frame.
REQ-011 stat_valid  out  1  one-cycle frame-status pulse.
REQ-012 stat_good, stat_crc_err, stat_len_err, stat_phy_err  out  1 each  frame verdict flags.
REQ-013 stat_len  out  11  body byte count, saturating at 2047.
REQ-014 stat_dst_port, stat_src_port  out  2 each  body byte 0 [1:0] and body byte 6 [1:0].
REQ-015 good_cnt, bad_cnt  out  16 each  frame statistics (see Configuration).

Function
REQ-016 FSM states: IDLE, PREAMBLE, BODY, DROP.
REQ-017 IDLE: rx_dv=1 and rx_data=0x55 -> PREAMBLE; rx_dv=1 with any other byte -> DROP.
REQ-018 PREAMBLE: 0x55 holds; 0xD5 -> BODY; any other byte -> DROP; rx_dv=0 -> IDLE with no stat_valid.
REQ-019 DROP: holds until rx_dv=0, then -> IDLE; it produces no output and no stat_valid.
REQ-020 BODY: each rx_dv=1 cycle is one body byte; the body count increments, saturating at 2047.
REQ-021 CRC: poly 0x04C11DB7, init 0xFFFFFFFF, byte bit-reversed on entry, no final inversion, computed over body bytes excluding the last 4.
REQ-022 The FCS is received as crc[31:24] first; a 4-byte delay line holds candidate FCS bytes.
REQ-023 Body byte i is presented on out_data with out_valid=1 on the cycle after body byte i+4 is sampled.
REQ-024 out_sof is high with body byte 0 only; bytes with index >= MAX_LEN-4 are not forwarded.
REQ-025 Frame end is the first rx_dv=0 sample in BODY; stat_valid pulses on the next cycle, then the FSM returns to IDLE.
REQ-026 stat_crc_err=1 if the delay line content != computed CRC.
REQ-027 stat_len_err=1 if len<MIN_LEN or len>MAX_LEN; len<4 forwards nothing and sets stat_crc_err=1.
REQ-028 stat_phy_err=1 if rx_er was sampled high in any BODY cycle; rx_er does not abort forwarding.
REQ-029 stat_good = no crc, len or phy error; stat_* hold their values until the next stat_valid.
REQ-030 rx_dv=1 in the stat_valid cycle is treated as an IDLE sample.

Reset
REQ-031 rst forces IDLE, clears the CRC to 0xFFFFFFFF, clears the delay line and count, and drives all outputs to 0.
REQ-032 rst mid-frame discards the frame with no stat_valid; the following frame is checked normally.

Configuration
REQ-033 With ETH_RX_STATS_EN defined: good_cnt and bad_cnt increment on stat_valid with stat_good=1 and stat_good=0 respectively, saturate at 0xFFFF, and are cleared by rst.
REQ-034 With ETH_RX_STATS_EN undefined: good_cnt and bad_cnt are constant 0 and no counter logic exists.

Verification
REQ-035 7x0x55, 0xD5, 64-byte body, DA byte0=0x01, SA byte0=0x03, valid FCS -> out_valid for exactly 60 beats, out_sof on beat 1; stat_valid with good=1, len=64, dst=1, src=3.
REQ-036 Same frame with body byte 30 XOR 0x01 -> stat_good=0, stat_crc_err=1; 60 bytes still forwarded.
REQ-037 40-byte body with valid FCS -> stat_len_err=1, stat_crc_err=0, stat_good=0; 1600-byte body -> len_err=1 and exactly MAX_LEN-4=1514 bytes forwarded.
REQ-038 Preamble 0x55, 0x12, ... -> no out_valid and no stat_valid; the next good frame passes with good=1.
REQ-039 rx_er high on body byte 20 -> stat_phy_err=1, good=0; rst at body byte 100 -> outputs 0, no stat_valid, next frame good.
REQ-040 With ETH_RX_STATS_EN: 3 good frames and 2 bad frames -> good_cnt=3, bad_cnt=2; without the macro, both counters read 0.
